uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each received byte, qualified by a one-cycle strobe, into a small synchronous FIFO. It presents the bytes to the consumer (bus interface or command parser) through a valid/ready handshake. It also tracks overflow and detects line-idle gaps so software can delimit variable-length messages.

## Interface

Parameters:
- `DEPTH_LOG2`, 4, FIFO depth is 2^DEPTH_LOG2 bytes (legal 2..8).
- `IDLE_WIDTH`, 16, width of the idle-gap timer and of `idle_div`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  8  received byte; sampled only when `in_stb` is high.
- `in_stb`  in  1  one-cycle strobe from the receiver, marking a valid byte.
- `out_data`  out  8  byte at FIFO head; valid only while `out_valid` is high.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head byte when `out_valid & out_ready`.
- `flush`  in  1  discard all FIFO contents.
- `level`  out  DEPTH_LOG2+1  number of stored bytes.
- `full`  out  1  `level == 2^DEPTH_LOG2`.
- `overflow`  out  1  sticky flag: a byte was dropped.
- `overflow_clr`  in  1  clears `overflow`.
- `idle_div`  in  IDLE_WIDTH  idle gap length in clk cycles; 0 disables idle detection.
- `idle`  out  1  one-cycle pulse at the end of an idle gap following received data.

## Operation

- Write: on `in_stb`, if not full, or if full and a pop happens in the same cycle, `in_data` is stored at the write pointer.
- Dropped byte: on `in_stb` while full with no pop, the byte is discarded, `overflow` is set, and FIFO contents are unchanged.
- Read: FIFO is first-word-fall-through. `out_data` is the head entry and `out_valid = ~empty`. A pop occurs on `out_valid & out_ready`; `out_ready` while empty has no effect.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. `level` is a DEPTH_LOG2+1-bit counter: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Flush: `flush` clears the pointers and `level` at the next edge. A push or pop in the same cycle is ignored (flush wins). Such a push does not set `overflow`. Flush does not affect `overflow` or the idle timer.
- Overflow: set wins over `overflow_clr` in the same cycle.
- Idle timer:
  - armed by `in_stb`, which loads the counter with `idle_div`;
  - while armed and no `in_stb`, the counter decrements;
  - when armed with counter 0, `idle` pulses and the timer disarms;
  - a new `in_stb` always reloads and re-arms;
  - `idle_div = 0` means the timer never arms.
- Reset: FIFO empty, pointers 0, `level` 0, `overflow` 0, timer disarmed with counter 0, `idle` 0.

## Timing

- Reset values: `out_valid` 0, `full` 0, `level` 0, `overflow` 0, `idle` 0. `out_data` is don't-care while `out_valid` is 0.
- Push latency: `in_stb` in cycle N makes `out_valid`, `level` and `full` update in cycle N+1.
- Pop: accepted in cycle N; the next head byte appears on `out_data` in cycle N+1.
- `overflow` rises in the cycle after the dropped `in_stb`. `overflow_clr` in cycle N clears it in N+1.
- `idle` is registered and high for exactly one cycle, in cycle N+D+1, where N is the last `in_stb` cycle and D is `idle_div` sampled at N.
- `flush` in cycle N gives `out_valid` 0 and `level` 0 in cycle N+1.
- Reset mid-operation: all state is cleared at the first edge with `rst_n` low. A strobe in that cycle is lost.

## Structure

- No shared package. Depth and widths are derived locally from the parameters.
- One sub-module: `uart_rx_fifo_mem`, a 2^DEPTH_LOG2 x 8 array with a synchronous write port and an asynchronous read port, for distributed-RAM inference.
- The top level holds the pointers, the level counter, the overflow flag and the idle timer.

## Test plan

- Basic flow: strobe 0x55, 0xAA, 0x01 with `out_ready` 0, then `out_ready` 1 → `level` reaches 3; `out_data` delivers 0x55, 0xAA, 0x01 on consecutive cycles; `out_valid` drops after the third pop.
- Full and overflow (DEPTH_LOG2=4): 17 strobes 0x00..0x10 with no reads → `full`=1, `overflow`=1 after the 17th; reads return 0x00..0x0F; `overflow_clr` clears the flag.
- Simultaneous push and pop when full: `in_stb` 0x77 with `out_ready`=1 → byte accepted, `level` stays 16, `overflow` stays 0, 0x77 emerges last.
- Idle: `idle_div`=10, single strobe in cycle 0 → `idle` pulses only in cycle 11. A strobe every 5 cycles produces no pulse until 11 cycles after the last strobe. `idle_div`=0 never pulses.
- Flush: 5 bytes stored, then `flush` coincident with `in_stb` 0x99 → `level`=0 and `out_valid`=0 next cycle, 0x99 dropped, `overflow` unchanged.
- Reset: `rst_n` low for one cycle with 8 bytes stored and `overflow`=1 → all outputs at reset values in the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Byte stream into and out of the UART receive FIFO.
//   in_data   : received byte, qualified by in_stb
//   in_stb    : one-cycle strobe marking a valid received byte
//   out_data  : byte at the FIFO head, meaningful while out_valid is high
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts the head byte when out_valid & out_ready
// Modports:
//   slave  : the FIFO (consumes in_*, produces out_data/out_valid)
//   master : the receiver/consumer side driving the FIFO
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if;
    logic [7:0] in_data;
    logic       in_stb;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  in_data,
        input  in_stb,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output in_data,
        output in_stb,
        output out_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_mem
// 2^ADDR_WIDTH x 8 storage array for the receive FIFO: one synchronous write
// port and one asynchronous read port, shaped for distributed-RAM inference.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module uart_rx_fifo_mem #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [7:0]            rdata
);
    logic [7:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset; occupancy is tracked by the pointers and
    // level, so stale contents are never observed and the RAM stays inferable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through byte FIFO behind the UART receiver, with a sticky
// overflow flag and an idle-gap detector for delimiting messages.
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   bus          : in_data/in_stb from the receiver, out_* handshake to consumer
//   flush        : discard all FIFO contents (wins over push/pop)
//   level        : number of stored bytes
//   full         : level == 2^DEPTH_LOG2
//   overflow     : sticky, set when a strobed byte is dropped
//   overflow_clr : clears overflow (a same-cycle set wins)
//   idle_div     : idle gap length in clk cycles, 0 disables detection
//   idle         : one-cycle pulse at the end of an idle gap after data
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IDLE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_fifo_if.slave         bus,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
    input  logic                  overflow_clr,
    input  logic [IDLE_WIDTH-1:0] idle_div,
    output logic                  idle
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LEVEL_W = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  idle_armed;
    logic [IDLE_WIDTH-1:0] idle_cnt;

    assign full          = (level == LEVEL_W'(DEPTH));
    assign bus.out_valid = (level != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push          = bus.in_stb & (~full | pop);
    // A strobe lost to a flush is discarded silently, not counted as overflow.
    assign drop          = bus.in_stb & full & ~pop & ~flush;

    uart_rx_fifo_mem #(
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (bus.out_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (push && !pop) begin
                level <= level + LEVEL_W'(1);
            end else if (pop && !push) begin
                level <= level - LEVEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // The counter holds the cycles left in the gap. The pulse is registered,
    // so it is issued on the edge where the count would reach zero; this puts
    // idle high exactly idle_div+1 cycles after the last strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_armed <= 1'b0;
            idle_cnt   <= '0;
            idle       <= 1'b0;
        end else begin
            idle <= 1'b0;
            if (bus.in_stb) begin
                idle_cnt   <= idle_div;
                idle_armed <= (idle_div != '0);
            end else if (idle_armed) begin
                idle_cnt <= idle_cnt - IDLE_WIDTH'(1);
                if (idle_cnt == IDLE_WIDTH'(1)) begin
                    idle       <= 1'b1;
                    idle_armed <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo (DEPTH_LOG2=4, IDLE_WIDTH=16). Inputs are
// driven and outputs sampled on the falling edge; the DUT acts on the rising
// edge, so a value sampled after one falling edge reflects the previous cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [4:0]  level;
    logic        full;
    logic        overflow;
    logic        overflow_clr;
    logic [15:0] idle_div;
    logic        idle;
    int          checks = 0;
    int          errors = 0;

    uart_rx_fifo_if u_if ();

    uart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .IDLE_WIDTH (16)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (u_if.slave),
        .flush        (flush),
        .level        (level),
        .full         (full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .idle_div     (idle_div),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] data);
        u_if.in_data = data;
        u_if.in_stb  = 1'b1;
        tick();
        u_if.in_stb  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", u_if.out_valid); end
        checks++;
        if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++;
        if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle got %b exp 0", idle); end
    endtask

    task automatic test_basic_flow();
        logic [7:0] exp [3] = '{8'h55, 8'hAA, 8'h01};
        for (int i = 0; i < 3; i++) strobe(exp[i]);
        checks++;
        if (level !== 5'd3) begin errors++; $display("FAIL basic_level got %0d exp 3", level); end
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== exp[i]) begin
                errors++;
                $display("FAIL basic_read%0d got v=%b d=%h exp v=1 d=%h", i, u_if.out_valid, u_if.out_data, exp[i]);
            end
            tick();
        end
        u_if.out_ready = 1'b0;
        checks++;
        if (u_if.out_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL basic_empty got v=%b lvl=%0d exp v=0 lvl=0", u_if.out_valid, level);
        end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 17; i++) begin
            strobe(8'(i));
            if (i == 15) begin
                checks++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL full_at16 got full=%b ovf=%b exp full=1 ovf=0", full, overflow);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || level !== 5'd16) begin
            errors++;
            $display("FAIL overflow_set got full=%b ovf=%b lvl=%0d exp 1 1 16", full, overflow, level);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clr got %b exp 0", overflow); end
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== 8'(i)) begin
                errors++;
                $display("FAIL full_read%0d got v=%b d=%h exp v=1 d=%h", i, u_if.out_valid, u_if.out_data, 8'(i));
            end
            tick();
        end
        u_if.out_ready = 1'b0;
        checks++;
        if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", u_if.out_valid); end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 16; i++) strobe(8'h20 + 8'(i));
        u_if.in_data   = 8'h77;
        u_if.in_stb    = 1'b1;
        u_if.out_ready = 1'b1;
        tick();
        u_if.in_stb    = 1'b0;
        checks++;
        if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || u_if.out_data !== 8'h21) begin
            errors++;
            $display("FAIL pushpop_full got lvl=%0d full=%b ovf=%b d=%h exp 16 1 0 21",
                     level, full, overflow, u_if.out_data);
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = (i == 15) ? 8'h77 : 8'h21 + 8'(i);
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== e) begin
                errors++;
                $display("FAIL pushpop_read%0d got v=%b d=%h exp v=1 d=%h", i, u_if.out_valid, u_if.out_data, e);
            end
            tick();
        end
        u_if.out_ready = 1'b0;
        checks++;
        if (u_if.out_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL pushpop_empty got v=%b lvl=%0d exp v=0 lvl=0", u_if.out_valid, level);
        end
    endtask

    // Cycle t: sample idle for cycle t, then drive the strobe for cycle t.
    task automatic idle_run(input logic [15:0] div, input int last_stb, input int pulse_at, input int len);
        int hits;
        hits     = 0;
        idle_div = div;
        for (int t = 0; t < len; t++) begin
            checks++;
            if (idle !== (t == pulse_at)) begin
                errors++;
                $display("FAIL idle_div%0d_t%0d got %b exp %b", div, t, idle, (t == pulse_at));
            end
            u_if.in_data = 8'hC0 + 8'(t);
            u_if.in_stb  = (t % 5 == 0) && (t <= last_stb);
            tick();
        end
        u_if.in_stb = 1'b0;
    endtask

    task automatic test_idle();
        idle_run(16'd10, 0, 11, 15);
        idle_run(16'd10, 15, 26, 32);
        idle_run(16'd0, 0, -1, 15);
        do_flush();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) strobe(8'h40 + 8'(i));
        checks++;
        if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got %0d exp 5", level); end
        u_if.in_data = 8'h99;
        u_if.in_stb  = 1'b1;
        flush        = 1'b1;
        tick();
        u_if.in_stb  = 1'b0;
        flush        = 1'b0;
        checks++;
        if (level !== 5'd0 || u_if.out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got lvl=%0d v=%b ovf=%b exp 0 0 0", level, u_if.out_valid, overflow);
        end
        tick();
        checks++;
        if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop99 got v=%b exp 0", u_if.out_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 17; i++) strobe(8'(i));
        do_flush();
        checks++;
        if (overflow !== 1'b1 || level !== 5'd0) begin
            errors++;
            $display("FAIL flush_keeps_ovf got ovf=%b lvl=%0d exp 1 0", overflow, level);
        end
        for (int i = 0; i < 8; i++) strobe(8'h80 + 8'(i));
        checks++;
        if (level !== 5'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL premid_state got lvl=%0d ovf=%b exp 8 1", level, overflow);
        end
        rst_n        = 1'b0;
        u_if.in_data = 8'hEE;
        u_if.in_stb  = 1'b1;
        tick();
        rst_n        = 1'b1;
        u_if.in_stb  = 1'b0;
        checks++;
        if (u_if.out_valid !== 1'b0 || level !== 5'd0 || full !== 1'b0 || overflow !== 1'b0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL midreset got v=%b lvl=%0d full=%b ovf=%b idle=%b exp all 0",
                     u_if.out_valid, level, full, overflow, idle);
        end
        tick();
        checks++;
        if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_stb_lost got v=%b exp 0", u_if.out_valid); end
    endtask

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        overflow_clr   = 1'b0;
        idle_div       = '0;
        u_if.in_data   = '0;
        u_if.in_stb    = 1'b0;
        u_if.out_ready = 1'b0;
        tick();
        test_reset();
        test_basic_flow();
        test_full_overflow();
        test_push_pop_full();
        test_idle();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
